// File: rtl/io_port_unit.sv
// I/O stage for the multicycle control unit: output FIFO toward a device, one-word input
// hold register, and a combinational stall for the control unit's in/out states.
module io_port_unit #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           OutputWrite,
    input  logic                           InputRead,
    input  logic [DATA_W-1:0]              OutData,
    output logic [DATA_W-1:0]              InData,
    output logic                           IoStall,
    output logic [$clog2(OUT_DEPTH):0]     OutCount,
    output logic [DATA_W-1:0]              DevOutData,
    output logic                           DevOutValid,
    input  logic                           DevOutReady,
    input  logic [DATA_W-1:0]              DevInData,
    input  logic                           DevInValid,
    output logic                           DevInReady
);

    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    logic [DATA_W-1:0] r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_hold;
    in_state_t         r_in_state;
    in_state_t         w_in_next;
    logic              w_capture;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_in_empty;

    // Full/empty come from the registered count, so a same-cycle pop never frees a stalled push
    assign w_full  = (r_count == CNT_W'(OUT_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = OutputWrite & ~w_full;
    assign w_pop   = ~w_empty & DevOutReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= OutData;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_in_state <= IN_EMPTY;
            r_hold     <= '0;
        end else begin
            r_in_state <= w_in_next;
            if (w_capture) r_hold <= DevInData;
        end
    end

    // Input FSM: a consume in IN_FULL returns to IN_EMPTY without capturing that cycle
    always_comb begin
        w_in_next = r_in_state;
        w_capture = 1'b0;
        case (r_in_state)
            IN_EMPTY: begin
                if (DevInValid) begin
                    w_in_next = IN_FULL;
                    w_capture = 1'b1;
                end
            end
            IN_FULL: begin
                if (InputRead) w_in_next = IN_EMPTY;
            end
            default: w_in_next = IN_EMPTY;
        endcase
    end

    assign w_in_empty  = (r_in_state == IN_EMPTY);
    assign InData      = r_hold;
    assign IoStall     = (OutputWrite & w_full) | (InputRead & w_in_empty);
    assign DevInReady  = w_in_empty & ~Reset;
    assign DevOutValid = ~w_empty;
    assign DevOutData  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign OutCount    = r_count;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: reset, FIFO fill/stall/drain, wrap-around,
// simultaneous push/pop, input stall/capture and mid-operation reset.
module tb_io_port_unit;

    logic        CLK;
    logic        Reset;
    logic        OutputWrite;
    logic        InputRead;
    logic [15:0] OutData;
    logic [15:0] InData;
    logic        IoStall;
    logic [2:0]  OutCount;
    logic [15:0] DevOutData;
    logic        DevOutValid;
    logic        DevOutReady;
    logic [15:0] DevInData;
    logic        DevInValid;
    logic        DevInReady;

    int checks;
    int failures;

    io_port_unit #(.DATA_W(16), .OUT_DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .OutputWrite(OutputWrite), .InputRead(InputRead),
        .OutData(OutData), .InData(InData), .IoStall(IoStall), .OutCount(OutCount),
        .DevOutData(DevOutData), .DevOutValid(DevOutValid), .DevOutReady(DevOutReady),
        .DevInData(DevInData), .DevInValid(DevInValid), .DevInReady(DevInReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        OutputWrite = 0; InputRead = 0; OutData = '0;
        DevOutReady = 0; DevInData = '0; DevInValid = 0;
        Reset = 0;
        #2 Reset = 1;
        #1;
        checks++; if (OutCount !== 3'd0) begin failures++; $display("FAIL rst_outcount got=%0d exp=0", OutCount); end
        checks++; if (DevOutValid !== 1'b0) begin failures++; $display("FAIL rst_devoutvalid got=%b exp=0", DevOutValid); end
        checks++; if (DevOutData !== 16'h0) begin failures++; $display("FAIL rst_devoutdata got=%h exp=0000", DevOutData); end
        checks++; if (InData !== 16'h0) begin failures++; $display("FAIL rst_indata got=%h exp=0000", InData); end
        checks++; if (DevInReady !== 1'b0) begin failures++; $display("FAIL rst_devinready got=%b exp=0", DevInReady); end
        checks++; if (IoStall !== 1'b0) begin failures++; $display("FAIL rst_iostall got=%b exp=0", IoStall); end
        step(); step();
        checks++; if (DevInReady !== 1'b0) begin failures++; $display("FAIL rst_devinready_held got=%b exp=0", DevInReady); end
        Reset = 0;
        step();
        checks++; if (DevInReady !== 1'b1) begin failures++; $display("FAIL rst_release_devinready got=%b exp=1", DevInReady); end
        checks++; if (OutCount !== 3'd0) begin failures++; $display("FAIL rst_release_outcount got=%0d exp=0", OutCount); end
    endtask

    task automatic test_fill_stall_drain();
        logic [15:0] words [5];
        logic [2:0]  cnts [5];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        words[3] = 16'h4444; words[4] = 16'h5555;
        cnts[0] = 3'd4; cnts[1] = 3'd3; cnts[2] = 3'd3; cnts[3] = 3'd2; cnts[4] = 3'd1;
        DevOutReady = 0;
        for (int i = 0; i < 4; i++) begin
            OutputWrite = 1; OutData = words[i];
            #1;
            checks++; if (IoStall !== 1'b0) begin failures++; $display("FAIL fill_nostall[%0d] got=%b exp=0", i, IoStall); end
            step();
        end
        OutData = 16'h5555;
        #1;
        checks++; if (OutCount !== 3'd4) begin failures++; $display("FAIL fill_outcount got=%0d exp=4", OutCount); end
        checks++; if (IoStall !== 1'b1) begin failures++; $display("FAIL fill_stall got=%b exp=1", IoStall); end
        step();
        checks++; if (OutCount !== 3'd4) begin failures++; $display("FAIL stall_outcount got=%0d exp=4", OutCount); end
        DevOutReady = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (DevOutData !== words[i] || DevOutValid !== 1'b1) begin
                failures++; $display("FAIL drain_head[%0d] got=%h/%b exp=%h/1", i, DevOutData, DevOutValid, words[i]); end
            checks++; if (OutCount !== cnts[i]) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, OutCount, cnts[i]); end
            checks++; if (IoStall !== (i == 0)) begin failures++; $display("FAIL drain_stall[%0d] got=%b exp=%b", i, IoStall, i == 0); end
            step();
            if (i == 1) OutputWrite = 0;
        end
        #1;
        checks++; if (DevOutValid !== 1'b0 || DevOutData !== 16'h0 || OutCount !== 3'd0) begin
            failures++; $display("FAIL drain_empty got=%b/%h/%0d exp=0/0000/0", DevOutValid, DevOutData, OutCount); end
        DevOutReady = 0;
    endtask

    task automatic test_wrap();
        logic [15:0] q [$];
        int pushed;
        int popped;
        int cyc;
        logic [15:0] head;
        pushed = 0; popped = 0; cyc = 0;
        while ((pushed < 10 || popped < 10) && cyc < 80) begin
            OutputWrite = (pushed < 10);
            OutData = 16'hA000 + 16'(pushed);
            DevOutReady = ((cyc % 3) != 0);
            #1;
            checks++; if (OutCount !== 3'(q.size()) || OutCount > 3'd4) begin
                failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", cyc, OutCount, q.size()); end
            checks++; if (IoStall !== (OutputWrite && q.size() == 4)) begin
                failures++; $display("FAIL wrap_stall[%0d] got=%b exp=%b", cyc, IoStall, OutputWrite && q.size() == 4); end
            if (q.size() != 0) begin
                checks++; if (DevOutValid !== 1'b1 || DevOutData !== q[0]) begin
                    failures++; $display("FAIL wrap_head[%0d] got=%h/%b exp=%h/1", cyc, DevOutData, DevOutValid, q[0]); end
            end else begin
                checks++; if (DevOutValid !== 1'b0) begin failures++; $display("FAIL wrap_valid[%0d] got=%b exp=0", cyc, DevOutValid); end
            end
            head = (q.size() != 0) ? q[0] : 16'h0;
            if (DevOutReady && q.size() != 0) begin
                checks++; if (head !== 16'hA000 + 16'(popped)) begin
                    failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", popped, head, 16'hA000 + 16'(popped)); end
                void'(q.pop_front());
                popped++;
            end
            if (OutputWrite && !(IoStall === 1'b1) && (q.size() < 4 || (DevOutReady && head != 16'h0 && 0))) begin
                q.push_back(OutData);
                pushed++;
            end
            step();
            cyc++;
        end
        checks++; if (popped != 10 || pushed != 10) begin
            failures++; $display("FAIL wrap_done pushed=%0d popped=%0d exp=10/10", pushed, popped); end
        OutputWrite = 0; DevOutReady = 0;
    endtask

    task automatic test_simul_push_pop();
        DevOutReady = 0; OutputWrite = 1;
        OutData = 16'hC001; step();
        OutData = 16'hC002; step();
        OutData = 16'hC003; DevOutReady = 1;
        #1;
        checks++; if (OutCount !== 3'd2 || DevOutData !== 16'hC001) begin
            failures++; $display("FAIL simul_before got=%0d/%h exp=2/c001", OutCount, DevOutData); end
        step();
        OutputWrite = 0; DevOutReady = 0;
        #1;
        checks++; if (OutCount !== 3'd2 || DevOutData !== 16'hC002) begin
            failures++; $display("FAIL simul_after got=%0d/%h exp=2/c002", OutCount, DevOutData); end
        DevOutReady = 1;
        step(); step();
        checks++; if (OutCount !== 3'd0 || DevOutValid !== 1'b0) begin
            failures++; $display("FAIL simul_drain got=%0d/%b exp=0/0", OutCount, DevOutValid); end
        DevOutReady = 0;
    endtask

    task automatic test_input_stall();
        InputRead = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (IoStall !== 1'b1 || DevInReady !== 1'b1) begin
                failures++; $display("FAIL in_stall[%0d] got=%b/%b exp=1/1", i, IoStall, DevInReady); end
            step();
        end
        DevInValid = 1; DevInData = 16'hBEEF;
        #1;
        checks++; if (IoStall !== 1'b1) begin failures++; $display("FAIL in_stall_valid got=%b exp=1", IoStall); end
        step();
        DevInValid = 0; DevInData = 16'h0;
        #1;
        checks++; if (InData !== 16'hBEEF || IoStall !== 1'b0 || DevInReady !== 1'b0) begin
            failures++; $display("FAIL in_capture got=%h/%b/%b exp=beef/0/0", InData, IoStall, DevInReady); end
        step();
        InputRead = 0;
        #1;
        checks++; if (DevInReady !== 1'b1) begin failures++; $display("FAIL in_consumed_ready got=%b exp=1", DevInReady); end
    endtask

    task automatic test_in_full_block();
        DevInValid = 1; DevInData = 16'h1234;
        step();
        DevInData = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (DevInReady !== 1'b0 || InData !== 16'h1234) begin
                failures++; $display("FAIL full_block[%0d] got=%b/%h exp=0/1234", i, DevInReady, InData); end
            step();
        end
        InputRead = 1;
        #1;
        checks++; if (IoStall !== 1'b0) begin failures++; $display("FAIL full_read_stall got=%b exp=0", IoStall); end
        step();
        InputRead = 0;
        #1;
        checks++; if (DevInReady !== 1'b1 || InData !== 16'h1234) begin
            failures++; $display("FAIL full_no_capture got=%b/%h exp=1/1234", DevInReady, InData); end
        step();
        DevInValid = 0;
        #1;
        checks++; if (InData !== 16'hA5A5 || DevInReady !== 1'b0) begin
            failures++; $display("FAIL full_recapture got=%h/%b exp=a5a5/0", InData, DevInReady); end
    endtask

    task automatic test_midop_reset();
        DevOutReady = 0; OutputWrite = 1;
        OutData = 16'h7777; step();
        OutData = 16'h8888; step();
        OutputWrite = 0;
        #2 Reset = 1;
        #1;
        checks++; if (OutCount !== 3'd0 || DevOutValid !== 1'b0 || DevOutData !== 16'h0) begin
            failures++; $display("FAIL midrst_fifo got=%0d/%b/%h exp=0/0/0000", OutCount, DevOutValid, DevOutData); end
        checks++; if (InData !== 16'h0 || DevInReady !== 1'b0) begin
            failures++; $display("FAIL midrst_input got=%h/%b exp=0000/0", InData, DevInReady); end
        step();
        Reset = 0;
        step();
        checks++; if (DevInReady !== 1'b1 || OutCount !== 3'd0) begin
            failures++; $display("FAIL midrst_release got=%b/%0d exp=1/0", DevInReady, OutCount); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fill_stall_drain();
        test_wrap();
        test_simul_push_pop();
        test_input_stall();
        test_in_full_block();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
